// File: rtl/pe_tile_scheduler.sv
// Tile sequencer: steers one shared operand stream to the PE group's W/I/O ports, then drains results.
// Data is combinational pass-through; only the phase FSM, beat counter and block counter are registered.
module pe_tile_scheduler #(
  parameter int DataWidth         = 32,
  parameter int W_Words           = 16,
  parameter int I_FirstWords      = 7,
  parameter int I_NextWords       = 4,
  parameter int O_Words           = 4,
  parameter int I_BlockCount      = 4,
  parameter int CountWidth        = 5,
  parameter int I_BlockCountWidth = 2
) (
  input  logic                         clk,
  input  logic                         aclr,
  input  logic                         Start,
  output logic                         Busy,
  output logic                         Done,
  output logic [I_BlockCountWidth-1:0] Block_Index,
  output logic [2:0]                   state_dbg,
  input  logic                         S_DataInValid,
  output logic                         S_DataInRdy,
  input  logic [DataWidth-1:0]         S_DataIn,
  output logic                         W_DataOutValid,
  input  logic                         W_DataOutRdy,
  output logic                         I_DataOutValid,
  input  logic                         I_DataOutRdy,
  output logic                         O_DataOutValid,
  input  logic                         O_DataOutRdy,
  output logic [DataWidth-1:0]         W_DataOut,
  output logic [DataWidth-1:0]         I_DataOut,
  output logic [DataWidth-1:0]         O_DataOut,
  input  logic                         R_DataInValid,
  output logic                         R_DataInRdy,
  input  logic [DataWidth-1:0]         R_DataIn,
  output logic                         R_DataOutValid,
  input  logic                         R_DataOutRdy,
  output logic [DataWidth-1:0]         R_DataOut
);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, LOAD_O, DRAIN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [CountWidth-1:0]        beat_cnt, beat_cnt_nxt;
  logic [I_BlockCountWidth-1:0] block_q, block_nxt;
  logic                         hs_s, hs_r, last_beat;
  logic [CountWidth-1:0]        i_last;

  // Handshake rule: a beat transfers when Valid and Rdy are both high in the same
  // cycle; each side may stall freely, and a port outside its phase sees Valid/Rdy = 0.
  assign W_DataOut = S_DataIn;
  assign I_DataOut = S_DataIn;
  assign O_DataOut = S_DataIn;
  assign R_DataOut = R_DataIn;

  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);
  assign Block_Index = block_q;
  assign state_dbg   = state;

  assign hs_s   = S_DataInValid & S_DataInRdy;
  assign hs_r   = R_DataOutValid & R_DataOutRdy;
  assign i_last = (block_q == '0) ? CountWidth'(I_FirstWords - 1) : CountWidth'(I_NextWords - 1);

  always_comb begin
    S_DataInRdy    = 1'b0;
    W_DataOutValid = 1'b0;
    I_DataOutValid = 1'b0;
    O_DataOutValid = 1'b0;
    R_DataInRdy    = 1'b0;
    R_DataOutValid = 1'b0;
    last_beat      = 1'b0;
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    block_nxt      = block_q;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt    = LOAD_W;
          beat_cnt_nxt = '0;
          block_nxt    = '0;
        end
      end
      LOAD_W: begin
        W_DataOutValid = S_DataInValid;
        S_DataInRdy    = W_DataOutRdy;
        last_beat      = (beat_cnt == CountWidth'(W_Words - 1));
        if (hs_s) begin
          beat_cnt_nxt = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) state_nxt = LOAD_I;
        end
      end
      LOAD_I: begin
        I_DataOutValid = S_DataInValid;
        S_DataInRdy    = I_DataOutRdy;
        last_beat      = (beat_cnt == i_last);
        if (hs_s) begin
          beat_cnt_nxt = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) state_nxt = LOAD_O;
        end
      end
      LOAD_O: begin
        O_DataOutValid = S_DataInValid;
        S_DataInRdy    = O_DataOutRdy;
        last_beat      = (beat_cnt == CountWidth'(O_Words - 1));
        if (hs_s) begin
          beat_cnt_nxt = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        R_DataOutValid = R_DataInValid;
        R_DataInRdy    = R_DataOutRdy;
        last_beat      = (beat_cnt == CountWidth'(O_Words - 1));
        if (hs_r) begin
          beat_cnt_nxt = last_beat ? '0 : beat_cnt + 1'b1;
          if (last_beat) begin
            // Weights stay resident across blocks, so later blocks restart at LOAD_I.
            if (block_q == I_BlockCountWidth'(I_BlockCount - 1)) begin
              state_nxt = DONE;
            end else begin
              state_nxt = LOAD_I;
              block_nxt = block_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state    <= IDLE;
      beat_cnt <= '0;
      block_q  <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      block_q  <= block_nxt;
    end
  end

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Bench for pe_tile_scheduler: builds the expected per-tile beat order (port + payload)
// in a queue and checks every observed handshake against it.
module tb_pe_tile_scheduler;
  localparam int DW = 32;
  localparam int EW = DW + 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD_W = 3'd1, ST_LOAD_O = 3'd3, ST_DRAIN = 3'd4;
  localparam logic [1:0] P_W = 2'd0, P_I = 2'd1, P_O = 2'd2, P_R = 2'd3;

  logic          clk = 1'b0;
  logic          aclr;
  logic          Start;
  logic          Busy, Done;
  logic [1:0]    Block_Index;
  logic [2:0]    state_dbg;
  logic          S_DataInValid, S_DataInRdy;
  logic [DW-1:0] S_DataIn;
  logic          W_DataOutValid, W_DataOutRdy;
  logic          I_DataOutValid, I_DataOutRdy;
  logic          O_DataOutValid, O_DataOutRdy;
  logic [DW-1:0] W_DataOut, I_DataOut, O_DataOut;
  logic          R_DataInValid, R_DataInRdy;
  logic [DW-1:0] R_DataIn;
  logic          R_DataOutValid, R_DataOutRdy;
  logic [DW-1:0] R_DataOut;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] s_q[$];
  logic [DW-1:0] r_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  pe_tile_scheduler dut (
    .clk(clk), .aclr(aclr), .Start(Start), .Busy(Busy), .Done(Done),
    .Block_Index(Block_Index), .state_dbg(state_dbg),
    .S_DataInValid(S_DataInValid), .S_DataInRdy(S_DataInRdy), .S_DataIn(S_DataIn),
    .W_DataOutValid(W_DataOutValid), .W_DataOutRdy(W_DataOutRdy),
    .I_DataOutValid(I_DataOutValid), .I_DataOutRdy(I_DataOutRdy),
    .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy),
    .W_DataOut(W_DataOut), .I_DataOut(I_DataOut), .O_DataOut(O_DataOut),
    .R_DataInValid(R_DataInValid), .R_DataInRdy(R_DataInRdy), .R_DataIn(R_DataIn),
    .R_DataOutValid(R_DataOutValid), .R_DataOutRdy(R_DataOutRdy), .R_DataOut(R_DataOut)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_s_rdy"}, S_DataInRdy, 0);
    check({tag, "_r_rdy"}, R_DataInRdy, 0);
    check({tag, "_valids"}, {W_DataOutValid, I_DataOutValid, O_DataOutValid, R_DataOutValid}, 0);
  endtask

  task automatic push_beats(input logic [1:0] code, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom();
      exp_q.push_back({code, d});
      if (code == P_R) r_q.push_back(d);
      else s_q.push_back(d);
    end
  endtask

  task automatic build_tile();
    exp_q.delete(); s_q.delete(); r_q.delete();
    push_beats(P_W, 16);
    for (int b = 0; b < 4; b++) begin
      push_beats(P_I, (b == 0) ? 7 : 4);
      push_beats(P_O, 4);
      push_beats(P_R, 4);
    end
  endtask

  // driver + monitor for one tile
  task automatic run_tile(input bit w_toggle, input bit r_stall, input bit start_again,
                          input bit abort, output int busy_cycles, output int done_cnt);
    int cyc, stall_left, o_b2, nhs;
    bit stalled, done_seen;
    logic [EW-1:0] got, exp;
    build_tile();
    cyc = 0; busy_cycles = 0; done_cnt = 0; stall_left = 0; o_b2 = 0;
    stalled = 0; done_seen = 0;
    while (cyc < 600 && !done_seen) begin
      @(negedge clk);
      Start         = (cyc == 0) || (start_again && cyc == 30);
      W_DataOutRdy  = w_toggle ? cyc[0] : 1'b1;
      I_DataOutRdy  = 1'b1;
      O_DataOutRdy  = 1'b1;
      if (r_stall && !stalled && state_dbg == ST_DRAIN && Block_Index == 2'd1) begin
        stall_left = 5; stalled = 1;
      end
      R_DataOutRdy  = (stall_left == 0);
      S_DataInValid = 1'b1;
      R_DataInValid = 1'b1;
      S_DataIn      = (s_q.size() != 0) ? s_q[0] : $urandom();
      R_DataIn      = (r_q.size() != 0) ? r_q[0] : $urandom();
      #1;
      if (cyc == 0) check("busy_before_start", Busy, 0);
      if (cyc == 1) begin
        check("busy_after_start", Busy, 1);
        check("start_state", state_dbg, ST_LOAD_W);
        check("start_block", Block_Index, 0);
      end
      if (stall_left > 0) begin
        check("stall_r_in_rdy", R_DataInRdy, 0);
        check("stall_state", state_dbg, ST_DRAIN);
        stall_left--;
      end
      if (abort && state_dbg == ST_LOAD_O && Block_Index == 2'd2 && o_b2 == 2) begin
        aclr = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_state", state_dbg, ST_IDLE);
        check("abort_block", Block_Index, 0);
        @(negedge clk);
        check("abort_no_done", Done, 0);
        aclr = 1'b1;
        exp_q.delete(); s_q.delete(); r_q.delete();
        return;
      end
      if (Busy) busy_cycles++;
      if (Done) begin
        done_cnt++;
        done_seen = 1;
        check("done_block_index", Block_Index, 3);
      end
      nhs = 0; got = '0;
      if (W_DataOutValid && W_DataOutRdy) begin nhs++; got = {P_W, W_DataOut}; end
      if (I_DataOutValid && I_DataOutRdy) begin nhs++; got = {P_I, I_DataOut}; end
      if (O_DataOutValid && O_DataOutRdy) begin
        nhs++; got = {P_O, O_DataOut};
        if (Block_Index == 2'd2) o_b2++;
      end
      if (R_DataOutValid && R_DataOutRdy) begin nhs++; got = {P_R, R_DataOut}; end
      if (nhs > 1) check("one_port_active", nhs, 1);
      if (nhs == 1) begin
        if (exp_q.size() == 0) begin
          check("beat_overflow", nhs, 0);
        end else begin
          exp = exp_q.pop_front();
          check("beat", got, exp);
          if (got[EW-1:DW] == P_R) begin
            if (r_q.size() != 0) void'(r_q.pop_front());
          end else begin
            if (s_q.size() != 0) void'(s_q.pop_front());
          end
        end
      end
      cyc++;
    end
    Start = 1'b0;
    check("tile_finished", done_seen, 1);
    check("tile_all_beats", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("post_tile_busy", Busy, 0);
    check("post_tile_done", Done, 0);
  endtask

  initial begin
    int busy_cycles, done_cnt;
    aclr = 1'b0; Start = 1'b0;
    S_DataInValid = 1'b1; S_DataIn = '0;
    R_DataInValid = 1'b1; R_DataIn = '0;
    W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1; R_DataOutRdy = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_block", Block_Index, 0);
    aclr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_quiet("idle");

    run_tile(0, 0, 1, 0, busy_cycles, done_cnt);
    check("plain_busy_cycles", busy_cycles, 68);
    check("plain_done_count", done_cnt, 1);

    run_tile(1, 0, 0, 0, busy_cycles, done_cnt);
    check("wstall_done_count", done_cnt, 1);

    run_tile(0, 1, 0, 0, busy_cycles, done_cnt);
    check("rstall_busy_cycles", busy_cycles, 73);
    check("rstall_done_count", done_cnt, 1);

    run_tile(0, 0, 0, 1, busy_cycles, done_cnt);
    check("abort_done_count", done_cnt, 0);
    @(negedge clk);
    #1;
    check_quiet("after_abort");

    run_tile(0, 0, 0, 0, busy_cycles, done_cnt);
    check("restart_busy_cycles", busy_cycles, 68);
    check("restart_done_count", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pe_tile_scheduler.md
# pe_tile_scheduler

Sequencer that sits between the shared on-chip operand buffer and the PE group. It takes one shared operand stream and steers each beat to the PE group's W, I or O input port in a fixed per-tile order. It then drains the accumulated results to a downstream consumer, repeating the I/O/drain sequence once per input block. Data paths are combinational pass-through; the block owns only the phase state machine, beat counters and block counter.

## Interface
- DataWidth, 32, operand/result width
- W_Words, 16, weight beats per tile (W_PEGroupSize × O_PEGroupSize)
- I_FirstWords, 7, input beats for block 0 (I_PEGroupSize)
- I_NextWords, 4, input beats for blocks 1..I_BlockCount-1 (bottom row only; others recirculate)
- O_Words, 4, partial-sum beats loaded and result beats drained per block
- I_BlockCount, 4, blocks per tile
- CountWidth, 5, beat-counter width (must hold max(W_Words, I_FirstWords, O_Words))
- I_BlockCountWidth, 2, block-counter width

Ports:
- clk  in  1  clock, rising edge
- aclr  in  1  asynchronous reset, active-low
- Start  in  1  begin one tile; sampled only in IDLE
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle pulse at tile completion
- Block_Index  out  I_BlockCountWidth  current block number
- S_DataInValid / S_DataInRdy  in / out  1 / 1  shared operand stream handshake
- S_DataIn  in  DataWidth  shared operand data
- W_DataOutValid / W_DataOutRdy  out / in  1 / 1  to PE group W port
- I_DataOutValid / I_DataOutRdy  out / in  1 / 1  to PE group I port
- O_DataOutValid / O_DataOutRdy  out / in  1 / 1  to PE group O port
- W_DataOut, I_DataOut, O_DataOut  out  DataWidth each  all driven from S_DataIn
- R_DataInValid / R_DataInRdy  in / out  1 / 1  result stream from PE group
- R_DataIn  in  DataWidth  result data
- R_DataOutValid / R_DataOutRdy  out / in  1 / 1  result stream to downstream
- R_DataOut  out  DataWidth  driven from R_DataIn

## Operation
- States: IDLE, LOAD_W, LOAD_I, LOAD_O, DRAIN, DONE.
- IDLE: when Start=1, go to LOAD_W and clear the beat counter and Block_Index.
- LOAD_W: W_DataOutValid = S_DataInValid, S_DataInRdy = W_DataOutRdy. Each handshake increments the beat counter. The beat at count W_Words-1 moves to LOAD_I and clears the counter.
- LOAD_I: same steering to the I port. The terminal count is I_FirstWords-1 when Block_Index=0, else I_NextWords-1. The terminal beat moves to LOAD_O.
- LOAD_O: same steering to the O port. The terminal count is O_Words-1. The terminal beat moves to DRAIN.
- DRAIN: R_DataOutValid = R_DataInValid, R_DataInRdy = R_DataOutRdy. Each downstream handshake counts. On the beat at O_Words-1:
  - if Block_Index = I_BlockCount-1, go to DONE;
  - otherwise increment Block_Index and go to LOAD_I. Weights are not reloaded.
- DONE: Done=1 for one cycle, then IDLE. Block_Index holds its last value until the next Start.
- A Valid or Rdy for a port is 0 outside that port's phase. S_DataInRdy is 0 in IDLE, DRAIN and DONE. R_DataInRdy is 0 outside DRAIN.
- Data buses are unconditional copies; only the handshakes are gated.
- Start outside IDLE is ignored.

## Timing
- Reset (aclr=0): state IDLE, counters 0, Block_Index 0, Busy 0, Done 0, all Valid/Rdy outputs 0.
- Reset mid-tile aborts immediately with no completion pulse.
- Zero-cycle latency: steered Valid/Rdy/data are combinational from the selected inputs. No beat is buffered.
- Phase change takes effect on the cycle after the terminal handshake. There are no bubbles beyond that one registered transition.
- Handshake = Valid & Rdy in the same cycle. Stalls on either side hold the counters.
- Tile with no stalls: Busy rises the cycle after Start. Total cycles = W_Words + I_FirstWords + (I_BlockCount-1)·I_NextWords + I_BlockCount·2·O_Words + 1 (DONE), i.e. 16+7+12+32+1 = 68 with defaults.
- Counter widths never overflow: counters clear on each terminal beat.

## Test plan
- Reset then idle, S_DataInValid=1 held: S_DataInRdy=0, all port Valids 0, Busy=0.
- Start, all Rdys=1, S valid every cycle, results valid every cycle:
  - W port receives exactly 16 beats, then I receives 7, O receives 4, 4 results are drained;
  - the next I phase is 4 beats;
  - Done pulses once after 68 busy cycles, with Block_Index=3 at completion.
- Same as above with W_DataOutRdy toggling every other cycle in LOAD_W: the counter holds on stalled cycles, exactly 16 W handshakes are counted, and no beat goes to I early.
- In block 1 DRAIN, R_DataOutRdy=0 for 5 cycles: R_DataInRdy=0 and the state holds DRAIN. The drain completes after Rdy returns and Block_Index goes 1→2.
- Pulse Start while Busy: no effect on state or counters.
- Deassert aclr midway through block 2 LOAD_O: the block returns to IDLE at once, all outputs are 0, and no Done pulse occurs. A new Start then begins again from LOAD_W with Block_Index 0.
